// File: rtl/spi_master_mc.sv
// SPI master with runtime clock divider, per-transfer mode/width and multiple chip selects.
// Config and tx word are captured at start; every output is a flop.
module spi_master_mc #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CS_NUM = 4,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned WID_W = $clog2(DATA_W),
    localparam int unsigned CS_W  = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [WID_W-1:0]  width,
    input  logic [DIV_W-1:0]  div,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              sck,
    output logic [CS_NUM-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned EC_W    = WID_W + 1;
    localparam int unsigned CS_SPAN = 1 << CS_W;
    // One bit per encodable cs_sel value; set where the index names a real slave.
    localparam logic [CS_SPAN-1:0] CS_VALID = CS_SPAN'({CS_SPAN{1'b1}} >> (CS_SPAN - CS_NUM));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [EC_W-1:0]     ec_q, ec_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic [WID_W-1:0]    width_q, width_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic                busy_d, done_d, sck_d, mosi_d;
    logic [DATA_W-1:0]   dout_d;
    logic [CS_NUM-1:0]   cs_n_d;

    logic                phase_end;
    logic                do_edge;
    logic [EC_W-1:0]     edge_idx;
    logic [DATA_W-1:0]   tx_shl;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ec_q    <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            width_q <= '0;
            div_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
            sck     <= 1'b0;
            cs_n    <= '1;
            mosi    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ec_q    <= ec_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            width_q <= width_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            busy    <= busy_d;
            done    <= done_d;
            dout    <= dout_d;
            sck     <= sck_d;
            cs_n    <= cs_n_d;
            mosi    <= mosi_d;
        end
    end

    // Next state; an SCK edge is taken at the start of each XFER phase (index edge_idx).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ec_d     = ec_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        width_d  = width_q;
        div_d    = div_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        busy_d   = busy;
        done_d   = 1'b0;
        dout_d   = dout;
        sck_d    = sck;
        cs_n_d   = cs_n;
        mosi_d   = mosi;
        do_edge  = 1'b0;
        edge_idx = '0;
        phase_end = (cnt_q == div_q);
        tx_shl    = tx_q << 1;

        case (state_q)
            ST_IDLE: begin
                if (start && CS_VALID[cs_sel]) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    width_d = width;
                    div_d   = div;
                    tx_d    = din;
                    rx_d    = '0;
                    busy_d  = 1'b1;
                    cs_n_d  = ~(CS_NUM'(1) << cs_sel);
                    sck_d   = cpol;
                    mosi_d  = cpha ? 1'b0 : din[width];
                end
            end
            ST_SETUP: begin
                if (phase_end) begin
                    state_d  = ST_XFER;
                    cnt_d    = '0;
                    ec_d     = '0;
                    do_edge  = 1'b1;
                    edge_idx = '0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_XFER: begin
                if (phase_end) begin
                    cnt_d = '0;
                    if (ec_q == {width_q, 1'b1}) begin
                        state_d = ST_HOLD;
                    end else begin
                        ec_d     = ec_q + EC_W'(1);
                        do_edge  = 1'b1;
                        edge_idx = ec_q + EC_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    cs_n_d  = '1;
                    mosi_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Even edges lead (away from cpol), odd edges trail.
        if (do_edge) begin
            sck_d = ~sck;
            if (!edge_idx[0]) begin
                if (!cpha_q) begin
                    rx_d = {rx_q[DATA_W-2:0], miso};
                end else if (edge_idx != '0) begin
                    tx_d   = tx_shl;
                    mosi_d = tx_shl[width_q];
                end else begin
                    mosi_d = tx_q[width_q];
                end
            end else begin
                if (cpha_q) begin
                    rx_d = {rx_q[DATA_W-2:0], miso};
                end else if (edge_idx != {width_q, 1'b1}) begin
                    tx_d   = tx_shl;
                    mosi_d = tx_shl[width_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: table vectors, random transfers against a spec-level model, corner sequences.
module tb_spi_master_mc;

    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [3:0]  width;
        logic [7:0]  div;
        logic [1:0]  cs_sel;
        logic [15:0] din;
        logic [15:0] sword;
        logic        loop;
        logic [15:0] exp_dout;
        logic [15:0] exp_rx;
        logic [3:0]  exp_cs_n;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, cpol, cpha;
    logic [3:0]  width;
    logic [7:0]  div;
    logic [1:0]  cs_sel;
    logic [15:0] din;
    logic        busy, done, sck, mosi, miso;
    logic [15:0] dout;
    logic [3:0]  cs_n;

    logic        start3;
    logic [1:0]  cs_sel3;
    logic        busy3, done3, sck3, mosi3;
    logic [15:0] dout3;
    logic [2:0]  cs_n3;

    // Behavioural slave state
    logic        s_cpol, s_cpha, loop, miso_s, prev_sck;
    logic [15:0] s_word, s_rx;
    int          s_bi, leads, trails;

    int n_checks = 0;
    int n_fail   = 0;

    assign miso = loop ? mosi : miso_s;

    always #5 clk = ~clk;

    spi_master_mc u_dut (
        .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha),
        .width(width), .div(div), .cs_sel(cs_sel), .din(din),
        .busy(busy), .done(done), .dout(dout), .sck(sck), .cs_n(cs_n),
        .mosi(mosi), .miso(miso)
    );

    spi_master_mc #(.CS_NUM(3)) u_oob (
        .clk(clk), .rst(rst), .start(start3), .cpol(cpol), .cpha(cpha),
        .width(width), .div(div), .cs_sel(cs_sel3), .din(din),
        .busy(busy3), .done(done3), .dout(dout3), .sck(sck3), .cs_n(cs_n3),
        .mosi(mosi3), .miso(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected results straight from the transfer rules: masked words, one-hot-low select, H*2*(w+2) busy cycles.
    function automatic vec_t model(input logic cp, input logic ch, input logic [3:0] w,
                                   input logic [7:0] dv, input logic [1:0] cs,
                                   input logic [15:0] dn, input logic [15:0] sw, input logic lp);
        vec_t r;
        int   mask;
        mask = (1 << (int'(w) + 1)) - 1;
        r.cpol = cp; r.cpha = ch; r.width = w; r.div = dv; r.cs_sel = cs;
        r.din = dn; r.sword = sw; r.loop = lp;
        r.exp_dout = 16'(int'(lp ? dn : sw) & mask);
        r.exp_rx   = 16'(int'(dn) & mask);
        r.exp_cs_n = ~(4'b0001 << cs);
        r.exp_lat  = (int'(dv) + 1) * 2 * (int'(w) + 2);
        return r;
    endfunction

    // Slave reacts at the negedge after each SCK change, well before the master's next sample.
    task automatic slave_step();
        if (sck !== prev_sck) begin
            if (sck != s_cpol) begin
                leads++;
                if (!s_cpha) begin
                    s_rx = {s_rx[14:0], mosi};
                end else begin
                    miso_s = s_word[s_bi];
                    if (s_bi > 0) s_bi--;
                end
            end else if (leads > trails) begin
                trails++;
                if (s_cpha) begin
                    s_rx = {s_rx[14:0], mosi};
                end else if (s_bi > 0) begin
                    s_bi--;
                    miso_s = s_word[s_bi];
                end
            end
        end
        prev_sck = sck;
    endtask

    task automatic do_xfer(input vec_t v, input int poke_at, input int abort_at);
        int lat;
        int nd;
        int bound;
        cpol = v.cpol; cpha = v.cpha; width = v.width; div = v.div;
        cs_sel = v.cs_sel; din = v.din;
        s_cpol = v.cpol; s_cpha = v.cpha; s_word = v.sword; s_bi = int'(v.width);
        leads = 0; trails = 0; s_rx = '0; loop = v.loop;
        miso_s = v.cpha ? 1'b0 : v.sword[v.width];
        prev_sck = sck;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("cs_n_active", cs_n, v.exp_cs_n);
        chk("sck_setup", sck, v.cpol);
        lat = 0;
        bound = 2 * v.exp_lat + 20;
        slave_step();
        while (!done && lat < bound) begin
            if (lat == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_sck", sck, 0);
                chk("rst_cs_n", cs_n, 4'hF);
                chk("rst_mosi", mosi, 0);
                chk("rst_dout", dout, 0);
                nd = 0;
                repeat (v.exp_lat + 10) begin
                    @(negedge clk);
                    if (done) nd++;
                end
                chk("rst_no_done", nd, 0);
                return;
            end
            if (lat == poke_at) begin
                start = 1'b1; din = ~v.din; width = 4'd15; cpol = ~v.cpol;
                cpha = ~v.cpha; div = 8'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
            slave_step();
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", lat, v.exp_lat);
        chk("dout", dout, v.exp_dout);
        chk("mosi_bits", s_rx, v.exp_rx);
        chk("sck_pulses", leads, int'(v.width) + 1);
        chk("busy_at_done", busy, 0);
        chk("cs_n_release", cs_n, 4'hF);
        @(negedge clk);
        chk("done_fall", done, 0);
        chk("sck_idle", sck, v.cpol);
        chk("mosi_idle", mosi, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        int   nd, nb, bad;
        int   dcyc[$];
        int   exp_per;

        rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; width = '0; div = '0;
        cs_sel = '0; din = '0; start3 = 1'b0; cs_sel3 = '0;
        s_cpol = 1'b0; s_cpha = 1'b0; loop = 1'b0; miso_s = 1'b0; prev_sck = 1'b0;
        s_word = '0; s_rx = '0; s_bi = 0; leads = 0; trails = 0;

        tbl[0] = '{1'b0, 1'b0, 4'd7,  8'd1,   2'd2, 16'h00A5, 16'h003C, 1'b0, 16'h003C, 16'h00A5, 4'b1011, 36};
        tbl[1] = '{1'b1, 1'b1, 4'd15, 8'd0,   2'd0, 16'hDEAD, 16'h0000, 1'b1, 16'hDEAD, 16'hDEAD, 4'b1110, 34};
        tbl[2] = '{1'b0, 1'b1, 4'd0,  8'd2,   2'd3, 16'h0001, 16'h0001, 1'b0, 16'h0001, 16'h0001, 4'b0111, 12};
        tbl[3] = '{1'b1, 1'b0, 4'd3,  8'd3,   2'd1, 16'hFF0C, 16'h123A, 1'b0, 16'h000A, 16'h000C, 4'b1101, 40};
        tbl[4] = '{1'b0, 1'b0, 4'd0,  8'd255, 2'd0, 16'h0000, 16'h0001, 1'b0, 16'h0001, 16'h0000, 4'b1110, 1024};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_cs_n", cs_n, 4'hF);
        chk("reset_sck", sck, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dout", dout, 0);
        chk("reset_mosi", mosi, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) do_xfer(tbl[i], -1, -1);

        // Random transfers against the model
        for (int i = 0; i < 24; i++) begin
            v = model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)));
            do_xfer(v, -1, -1);
        end

        // start pulsed mid-transfer with different config: ignored, transfer intact
        v = model(1'b0, 1'b0, 4'd7, 8'd1, 2'd2, 16'h00A5, 16'h003C, 1'b0);
        do_xfer(v, 5, -1);
        nd = 0; nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        chk("poke_no_extra_done", nd, 0);
        chk("poke_no_restart", nb, 0);

        // Out-of-range chip select on the 3-slave instance
        cs_sel3 = 2'd3; start3 = 1'b1; width = 4'd0; div = 8'd0;
        bad = 0;
        @(negedge clk);
        start3 = 1'b0;
        repeat (10) begin
            if (busy3 || done3 || cs_n3 != 3'b111) bad++;
            @(negedge clk);
        end
        chk("oob_ignored", bad, 0);
        chk("oob_cs_n", cs_n3, 3'b111);
        cs_sel3 = 2'd2; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("oob_valid_busy", busy3, 1);
        chk("oob_valid_cs_n", cs_n3, 3'b011);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done3) nd++;
        end
        chk("oob_valid_done", nd, 1);

        // Reset during XFER of a mode-1 transfer, then a clean 8'h81 transfer
        v = model(1'b0, 1'b1, 4'd7, 8'd1, 2'd1, 16'h00F0, 16'h0055, 1'b0);
        do_xfer(v, -1, 8);
        v = model(1'b0, 1'b1, 4'd7, 8'd1, 2'd0, 16'h0081, 16'h0081, 1'b0);
        do_xfer(v, -1, -1);

        // Back-to-back single-bit transfers with start held high
        cpol = 1'b0; cpha = 1'b0; width = 4'd0; div = 8'd0; cs_sel = 2'd1;
        din = 16'h0001; loop = 1'b1; start = 1'b1;
        v = model(1'b0, 1'b0, 4'd0, 8'd0, 2'd1, 16'h0001, 16'h0000, 1'b1);
        exp_per = v.exp_lat + 1;
        for (int c = 0; c < 60 && dcyc.size() < 4; c++) begin
            @(negedge clk);
            if (done) begin
                dcyc.push_back(c);
                chk("b2b_dout", dout, v.exp_dout);
            end
        end
        start = 1'b0;
        chk("b2b_count", dcyc.size(), 4);
        for (int i = 1; i < dcyc.size(); i++) chk("b2b_period", dcyc[i] - dcyc[i-1], exp_per);
        repeat (12) @(negedge clk);
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_cs_n", cs_n, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
